// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath types: register index, 32-bit word and the
// writeback request carried through the long-unit result FIFO.
package cpu_defs;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] u32_t;

  typedef struct packed {
    reg_idx_t idx;
    u32_t     data;
  } wb_req_t;

  // Source that owns the regfile write port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_WB     = 2'd1,
    GNT_HEAD   = 2'd2,
    GNT_BYPASS = 2'd3
  } gnt_src_e;

  // One-hot register mask; x0 never gets a bit because it is never tracked.
  function automatic logic [31:0] idx_bit(reg_idx_t i);
    logic [31:0] m;
    m = '0;
    if (i != '0) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Synchronous FIFO of pending long-unit writeback requests with a
// single-cycle flush that discards every queued entry.
module wb_result_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush_i,
  input  logic    push_i,
  input  wb_req_t data_i,
  input  logic    pop_i,
  output wb_req_t data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  wb_req_t        mem_q [DEPTH];
  logic    [AW:0] wr_q, wr_d;
  logic    [AW:0] rd_q, rd_d;
  logic           do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: Writeback has priority, long-unit results
// queue and drain in idle cycles, with a forced drain after MAX_WAIT.
module wb_port_arbiter
  import cpu_defs::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush_i,
  input  logic     wb_we,
  input  reg_idx_t wb_idx,
  input  u32_t     wb_data,
  output logic     wb_stall_req,
  input  logic     lu_valid,
  output logic     lu_ready,
  input  reg_idx_t lu_idx,
  input  u32_t     lu_data,
  input  logic     iss_valid,
  input  reg_idx_t iss_idx,
  input  reg_idx_t rs1_idx,
  input  reg_idx_t rs2_idx,
  input  reg_idx_t rd_idx,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     rd_busy,
  output logic     reg_we,
  output reg_idx_t reg_idx,
  output u32_t     reg_data,
  output logic     err_o
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(MAX_WAIT - 1);
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);

  gnt_src_e          gnt;
  wb_req_t           head, lu_req;
  logic              fifo_full, fifo_empty;
  logic              lu_hs, push, pop_head, head_waiting;
  reg_idx_t          wr_idx;
  u32_t              wr_data;
  logic [31:0]       busy_q, busy_d, set_mask, clr_mask;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              force_q, force_d;
  logic              err_q, err_d;

  assign lu_req = '{idx: lu_idx, data: lu_data};

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (lu_req),
    .pop_i   (pop_head),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Grant: forced drain, then Writeback, then queued head, then bypass.
  always_comb begin
    gnt = GNT_NONE;
    if (force_q && !fifo_empty) gnt = GNT_HEAD;
    else if (wb_we)             gnt = GNT_WB;
    else if (!fifo_empty)       gnt = GNT_HEAD;
    else if (lu_valid)          gnt = GNT_BYPASS;
  end

  always_comb begin
    wr_idx  = '0;
    wr_data = '0;
    unique case (gnt)
      GNT_WB:     begin wr_idx = wb_idx;   wr_data = wb_data;   end
      GNT_HEAD:   begin wr_idx = head.idx; wr_data = head.data; end
      GNT_BYPASS: begin wr_idx = lu_idx;   wr_data = lu_data;   end
      GNT_NONE:   begin wr_idx = '0;       wr_data = '0;        end
    endcase
  end

  assign reg_we   = (gnt != GNT_NONE) && (wr_idx != '0);
  assign reg_idx  = wr_idx;
  assign reg_data = wr_data;

  assign lu_ready     = ~fifo_full;
  assign lu_hs        = lu_valid & ~fifo_full;
  assign push         = lu_hs & (gnt != GNT_BYPASS);
  assign pop_head     = (gnt == GNT_HEAD);
  assign head_waiting = !fifo_empty && !pop_head;
  assign wb_stall_req = force_q;

  // Scoreboard: a long result clears its bit, a same-cycle issue re-sets it.
  always_comb begin
    set_mask = iss_valid ? idx_bit(iss_idx) : '0;
    clr_mask = (gnt == GNT_HEAD || gnt == GNT_BYPASS) ? idx_bit(wr_idx) : '0;
    busy_d   = flush_i ? '0 : ((busy_q & ~clr_mask) | set_mask);
    err_d    = err_q
             | (iss_valid && |(busy_q & idx_bit(iss_idx)))
             | ((gnt == GNT_WB) && |(busy_q & idx_bit(wb_idx)));
  end

  assign rs1_busy = busy_q[rs1_idx];
  assign rs2_busy = busy_q[rs2_idx];
  assign rd_busy  = busy_q[rd_idx];

  // Age of the FIFO head; the forced drain lasts exactly one cycle.
  always_comb begin
    age_d   = '0;
    force_d = 1'b0;
    if (!flush_i && head_waiting) begin
      if (age_q == AGE_LAST) force_d = 1'b1;
      else                   age_d   = age_q + AGE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      age_q   <= '0;
      force_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      age_q   <= age_d;
      force_q <= force_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based model of the
// write-port rules, plus directed scenarios with literal expectations.
module tb_wb_port_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic        wb_we, wb_stall_req;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_idx;
  logic [31:0] lu_data;
  logic        iss_valid;
  logic [4:0]  iss_idx, rs1_idx, rs2_idx, rd_idx;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        reg_we;
  logic [4:0]  reg_idx;
  logic [31:0] reg_data;
  logic        err_o;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data), .wb_stall_req(wb_stall_req),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_idx(lu_idx), .lu_data(lu_data),
    .iss_valid(iss_valid), .iss_idx(iss_idx),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model state: pending long results as a queue, busy set, head age.
  logic [36:0] mq[$];
  bit [31:0]   m_busy;
  int          m_wait;
  bit          m_force, m_err;
  bit          last_hs, last_stall;

  always @(negedge clk) begin
    int          src;
    bit          hq, hs, e_we;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
    logic [36:0] h;
    hq = (mq.size() > 0);
    h  = hq ? mq[0] : '0;
    if (m_force && hq) src = 2;
    else if (wb_we)    src = 1;
    else if (hq)       src = 2;
    else if (lu_valid) src = 3;
    else               src = 0;
    case (src)
      1:       begin e_idx = wb_idx;   e_data = wb_data;  end
      2:       begin e_idx = h[36:32]; e_data = h[31:0];  end
      3:       begin e_idx = lu_idx;   e_data = lu_data;  end
      default: begin e_idx = '0;       e_data = '0;       end
    endcase
    e_we = (src != 0) && (e_idx != 0);
    check("reg_we", reg_we, e_we);
    if (e_we) begin
      check("reg_idx", reg_idx, e_idx);
      check("reg_data", reg_data, e_data);
    end
    check("lu_ready", lu_ready, mq.size() < DEPTH);
    check("wb_stall_req", wb_stall_req, m_force);
    check("err_o", err_o, m_err);
    check("rs1_busy", rs1_busy, m_busy[rs1_idx]);
    check("rs2_busy", rs2_busy, m_busy[rs2_idx]);
    check("rd_busy", rd_busy, m_busy[rd_idx]);

    hs         = lu_valid && (mq.size() < DEPTH);
    last_hs    = hs;
    last_stall = m_force;
    if (rst) begin
      mq.delete(); m_busy = '0; m_wait = 0; m_force = 0; m_err = 0;
    end else begin
      if (iss_valid && iss_idx != 0 && m_busy[iss_idx]) m_err = 1;
      if (src == 1 && wb_idx != 0 && m_busy[wb_idx])    m_err = 1;
      if (flush_i) begin
        mq.delete(); m_busy = '0; m_wait = 0; m_force = 0;
      end else begin
        if (src == 2 || src == 3) m_busy[e_idx] = 1'b0;
        if (iss_valid && iss_idx != 0) m_busy[iss_idx] = 1'b1;
        if (src == 2) void'(mq.pop_front());
        if (hs && src != 3) mq.push_back({lu_idx, lu_data});
        if (hq && src != 2) begin
          m_wait++;
          if (m_wait == MAX_WAIT) begin m_force = 1; m_wait = 0; end
          else m_force = 0;
        end else begin
          m_wait = 0; m_force = 0;
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #2; endtask

  task automatic idle();
    flush_i = 0; wb_we = 0; wb_idx = 0; wb_data = 0;
    lu_valid = 0; lu_idx = 0; lu_data = 0; iss_valid = 0; iss_idx = 0;
    rs1_idx = 0; rs2_idx = 0; rd_idx = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  logic [4:0] pend[$];

  task automatic drive_random(int n, int wb_pct);
    bit flush_prev = 0;
    for (int c = 0; c < n; c++) begin
      logic [4:0] cand;
      tick();
      rs1_idx = 5'($urandom); rs2_idx = 5'($urandom); rd_idx = 5'($urandom);
      if (flush_prev) begin pend.delete(); lu_valid = 0; end
      if (!(last_stall && wb_we)) begin
        wb_we = ($urandom_range(99) < wb_pct);
        wb_idx = 0;
        for (int t = 0; t < 8; t++) begin
          cand = 5'($urandom);
          if (!m_busy[cand]) begin wb_idx = cand; break; end
        end
        wb_data = $urandom;
      end
      if (!(lu_valid && !last_hs)) begin
        lu_valid = 0;
        if (pend.size() > 0 && $urandom_range(99) < 50) begin
          int j = $urandom_range(pend.size() - 1);
          lu_idx = pend[j]; pend.delete(j);
          lu_valid = 1; lu_data = $urandom;
        end else if ($urandom_range(99) < 5) begin
          lu_idx = 0; lu_valid = 1; lu_data = $urandom;
        end
      end
      flush_i   = ($urandom_range(59) == 0) && !flush_prev;
      iss_valid = 0;
      if (!flush_i && $urandom_range(99) < 30) begin
        for (int t = 0; t < 8; t++) begin
          cand = 5'($urandom_range(31, 1));
          if (!m_busy[cand] && !(wb_we && cand == wb_idx)) begin
            iss_valid = 1; iss_idx = cand; pend.push_back(cand); break;
          end
        end
      end
      flush_prev = flush_i;
    end
    tick(); idle(); pend.delete();
    for (int c = 0; c < 12; c++) tick();
  endtask

  initial begin
    idle(); rst = 1;
    tick(); settle();
    check("rst_lu_ready", lu_ready, 1'b1);
    check("rst_stall", wb_stall_req, 1'b0);
    check("rst_err", err_o, 1'b0);
    tick(); rst = 0;

    // Bypass
    tick(); iss_valid = 1; iss_idx = 7;
    tick(); iss_valid = 0; lu_valid = 1; lu_idx = 7; lu_data = 32'h1234; rd_idx = 7;
    settle();
    check("byp_we", reg_we, 1'b1); check("byp_idx", reg_idx, 5'd7);
    check("byp_data", reg_data, 32'h1234); check("byp_busy_before", rd_busy, 1'b1);
    tick(); lu_valid = 0; settle();
    check("byp_busy_after", rd_busy, 1'b0);

    // Priority and queueing
    iss_valid = 1; iss_idx = 9;
    tick(); iss_valid = 0;
    wb_we = 1; wb_idx = 3; wb_data = 32'hA; lu_valid = 1; lu_idx = 9; lu_data = 32'hB;
    settle();
    check("pri_idx", reg_idx, 5'd3); check("pri_data", reg_data, 32'hA);
    tick(); wb_we = 0; lu_valid = 0; settle();
    check("q_we", reg_we, 1'b1); check("q_idx", reg_idx, 5'd9); check("q_data", reg_data, 32'hB);
    tick();

    // Backpressure
    do_reset();
    iss_valid = 1; iss_idx = 10; tick(); iss_idx = 11; tick(); iss_idx = 12; tick();
    iss_valid = 0; wb_we = 1; wb_idx = 2; wb_data = 32'hC0;
    lu_valid = 1; lu_idx = 10; lu_data = 32'h100; tick();
    lu_idx = 11; lu_data = 32'h101; tick();
    lu_idx = 12; lu_data = 32'h102; settle();
    check("bp_full0", lu_ready, 1'b0);
    tick(); settle(); check("bp_full1", lu_ready, 1'b0);
    tick(); wb_we = 0; settle();
    check("bp_drain_idx", reg_idx, 5'd10); check("bp_drain_data", reg_data, 32'h100);
    check("bp_still_full", lu_ready, 1'b0);
    tick(); settle();
    check("bp_idx11", reg_idx, 5'd11); check("bp_ready", lu_ready, 1'b1);
    tick(); lu_valid = 0; settle();
    check("bp_idx12", reg_idx, 5'd12); check("bp_data12", reg_data, 32'h102);
    tick();

    // Starvation
    do_reset();
    iss_valid = 1; iss_idx = 5;
    tick(); iss_valid = 0; wb_we = 1; wb_idx = 1; wb_data = 32'h77;
    lu_valid = 1; lu_idx = 5; lu_data = 32'h55;
    tick(); lu_valid = 0;
    for (int k = 0; k < MAX_WAIT; k++) begin
      settle();
      check("starve_nostall", wb_stall_req, 1'b0);
      check("starve_wb_idx", reg_idx, 5'd1);
      tick();
    end
    settle();
    check("force_stall", wb_stall_req, 1'b1); check("force_we", reg_we, 1'b1);
    check("force_idx", reg_idx, 5'd5); check("force_data", reg_data, 32'h55);
    tick(); settle();
    check("force_done", wb_stall_req, 1'b0);
    check("repres_idx", reg_idx, 5'd1); check("repres_data", reg_data, 32'h77);
    tick(); wb_we = 0;

    // Scoreboard
    do_reset();
    iss_valid = 1; iss_idx = 12;
    tick(); iss_valid = 0; rs1_idx = 12; settle();
    check("sb_rs1_busy", rs1_busy, 1'b1); check("sb_err0", err_o, 1'b0);
    iss_valid = 1; iss_idx = 12;
    tick(); iss_valid = 0; settle(); check("sb_err_reiss", err_o, 1'b1);
    iss_valid = 1; iss_idx = 4;
    tick(); lu_valid = 1; lu_idx = 4; lu_data = 32'h44;
    tick(); iss_valid = 0; lu_valid = 0; rs2_idx = 4; settle();
    check("sb_set_wins", rs2_busy, 1'b1);
    do_reset(); settle(); check("sb_err_rst", err_o, 1'b0);
    iss_valid = 1; iss_idx = 6;
    tick(); iss_valid = 0; wb_we = 1; wb_idx = 6; wb_data = 32'h6;
    tick(); wb_we = 0; settle(); check("sb_err_wb", err_o, 1'b1);

    // Flush
    do_reset();
    iss_valid = 1; iss_idx = 20; tick(); iss_idx = 21; tick();
    iss_valid = 0; wb_we = 1; wb_idx = 2; wb_data = 32'h22;
    lu_valid = 1; lu_idx = 20; lu_data = 32'h20; tick();
    lu_idx = 21; lu_data = 32'h21; tick();
    lu_valid = 0; flush_i = 1; settle();
    check("fl_wb_write", reg_idx, 5'd2);
    tick(); flush_i = 0; wb_we = 0; rs1_idx = 20; rs2_idx = 21; settle();
    check("fl_ready", lu_ready, 1'b1); check("fl_rs1", rs1_busy, 1'b0);
    check("fl_rs2", rs2_busy, 1'b0); check("fl_no_we", reg_we, 1'b0);
    tick(); settle(); check("fl_no_we2", reg_we, 1'b0);

    // Reset mid-count
    do_reset();
    iss_valid = 1; iss_idx = 5;
    tick(); iss_valid = 0; wb_we = 1; wb_idx = 1; wb_data = 32'h9;
    lu_valid = 1; lu_idx = 5; lu_data = 32'h5;
    tick(); lu_valid = 0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 12; k++) begin
      settle(); check("rst_mid_nostall", wb_stall_req, 1'b0); tick();
    end
    wb_we = 0;

    do_reset();
    drive_random(1500, 40);
    drive_random(1000, 92);
    drive_random(600, 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
